call_rr_scheduler: RTL
======================

CALL_RR_SCHEDULER -- requirements
Module: call_rr_scheduler

Interface
REQ-001 SHALL have parameter PARENT, default 8: number of requesting parent ports.
REQ-002 SHALL have parameter CHILD, default 16: number of child function units.
REQ-003 SHALL have parameter ARG_DW, default 64: call argument payload width.
REQ-004 SHALL have parameter STARVE_LIMIT, default 15: wait cycles before a parent is promoted (1..255).
REQ-005 SHALL derive localparams LOG_PARENT and LOG_CHILD as clog2 of PARENT and CHILD, with a minimum of 1.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port req_vld_i, input, PARENT: per-parent call request valid.
REQ-009 SHALL have port req_child_i, input, PARENT x LOG_CHILD: target child index per parent.
REQ-010 SHALL have port req_args_i, input, PARENT x ARG_DW: argument payload per parent.
REQ-011 SHALL have port req_rdy_o, output, PARENT: one-hot accept pulse to the granted parent.
REQ-012 SHALL have port call_vld_o, output, CHILD: one-hot issue valid to the target child.
REQ-013 SHALL have port call_rdy_i, input, CHILD: child ready to take a call.
REQ-014 SHALL have port call_parent_o, output, LOG_PARENT: parent index of the issued call.
REQ-015 SHALL have port call_args_o, output, ARG_DW: payload of the issued call.
REQ-016 SHALL have port child_done_i, input, CHILD: single-cycle completion pulse per child.
REQ-017 SHALL have port child_busy_o, output, CHILD: child has an outstanding call.

Function
REQ-018 SHALL implement a two-state issue FSM (IDLE, ISSUE) holding one registered call (parent, child, args).
REQ-019 In IDLE, SHALL treat a parent as eligible when req_vld_i=1 and the target child is neither busy nor the target of the held call.
REQ-020 SHALL grant the first eligible parent in round-robin order, starting at pointer rr_ptr.
REQ-021 On grant, SHALL pulse req_rdy_o for the winner in the same cycle, latch its request, enter ISSUE, and set rr_ptr = winner+1 mod PARENT.
REQ-022 In ISSUE, SHALL drive call_vld_o[held child]=1 with call_parent_o/call_args_o stable until call_rdy_i[held child]=1.
REQ-023 On the handshake cycle, SHALL set busy[held child] and return to IDLE; next grant is no earlier than the following cycle (issue rate 1 call per 2 cycles).
REQ-024 SHALL clear busy[c] on child_done_i[c]=1.
REQ-025 If a handshake and a done arrive on the same child in the same cycle, SHALL leave busy set (set wins).
REQ-026 SHALL ignore child_done_i on a non-busy child, with no state change.
REQ-027 With no eligible parent, SHALL remain in IDLE with rr_ptr unchanged and all req_rdy_o at 0.
REQ-028 SHALL allow a parent to drop req_vld_i before grant without error; requests are not latched until granted.
REQ-029 SHALL assert child_busy_o = busy register.

Reset
REQ-030 On rstn=0, SHALL asynchronously force: FSM=IDLE, rr_ptr=0, busy=0, req_rdy_o=0, call_vld_o=0, call_parent_o=0, call_args_o=0, starve counters=0.
REQ-031 If reset asserts mid-ISSUE, SHALL drop the held call with no handshake.

Configuration
REQ-032 Macro CALL_SCHED_STARVE_EN SHALL enable a per-parent 8-bit saturating wait counter.
REQ-033 With CALL_SCHED_STARVE_EN: the counter increments each IDLE cycle a parent is eligible but not granted; it clears on grant or when req_vld_i=0.
REQ-034 With CALL_SCHED_STARVE_EN: parents with counter >= STARVE_LIMIT SHALL take priority over round-robin, lowest index first; rr_ptr still updates to winner+1.
REQ-035 Without CALL_SCHED_STARVE_EN, SHALL build no counters and use pure round-robin.

Verification
REQ-036 After reset, all parents request child 3 with call_rdy_i=all-1 and no done: only parent 0 is granted; busy[3]=1; no further grants until child_done_i[3].
REQ-037 Parents 0,1,2 request children 1,2,3 with rdy=1: grants go 0,1,2 on cycles 0,2,4; call_parent_o matches; busy=0b1110.
REQ-038 Hold call_rdy_i[5]=0 for 4 cycles on a call to child 5 with args=0xDEADBEEF: call_vld_o[5] stays 1 and args stay stable; accept occurs on cycle 5.
REQ-039 Handshake on child 2 with child_done_i[2] in the same cycle: busy[2] remains 1.
REQ-040 Assert rstn=0 during ISSUE: call_vld_o=0 immediately; after release, the first grant goes to parent 0.
REQ-041 With CALL_SCHED_STARVE_EN and STARVE_LIMIT=2: parent 7 is blocked by round-robin for 2 eligible cycles, then granted ahead of parent 0.

Source files
------------

// File: rtl/call_rr_scheduler.sv
// Round-robin call dispatcher: PARENT requesters issue one registered call at a time to CHILD units.
// Defining CALL_SCHED_STARVE_EN adds per-parent wait counters that promote long-waiting parents.
module call_rr_scheduler #(
  parameter int PARENT       = 8,
  parameter int CHILD        = 16,
  parameter int ARG_DW       = 64,
  parameter int STARVE_LIMIT = 15,
  localparam int LOG_PARENT  = (PARENT > 1) ? $clog2(PARENT) : 1,
  localparam int LOG_CHILD   = (CHILD > 1) ? $clog2(CHILD) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [PARENT-1:0]             req_vld_i,
  input  logic [PARENT*LOG_CHILD-1:0]   req_child_i,
  input  logic [PARENT*ARG_DW-1:0]      req_args_i,
  output logic [PARENT-1:0]             req_rdy_o,
  output logic [CHILD-1:0]              call_vld_o,
  input  logic [CHILD-1:0]              call_rdy_i,
  output logic [LOG_PARENT-1:0]         call_parent_o,
  output logic [ARG_DW-1:0]             call_args_o,
  input  logic [CHILD-1:0]              child_done_i,
  output logic [CHILD-1:0]              child_busy_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [LOG_PARENT-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CHILD-1:0]       busy_q, busy_d;
  logic [LOG_PARENT-1:0]  held_parent_q, held_parent_d;
  logic [LOG_CHILD-1:0]   held_child_q, held_child_d;
  logic [ARG_DW-1:0]      held_args_q, held_args_d;

  logic [LOG_CHILD-1:0]   req_child [PARENT];
  logic [ARG_DW-1:0]      req_args  [PARENT];
  logic [PARENT-1:0]      child_ok;
  logic [PARENT-1:0]      eligible;
  logic [PARENT-1:0]      grant;
  logic [CHILD-1:0]       set_busy;

  logic                   rr_found;
  logic [LOG_PARENT-1:0]  rr_winner;
  logic [LOG_PARENT:0]    rr_idx;
  logic                   any_found;
  logic [LOG_PARENT-1:0]  winner;

  generate
    for (genvar gi = 0; gi < PARENT; gi++) begin : g_req
      assign req_child[gi] = req_child_i[gi*LOG_CHILD +: LOG_CHILD];
      assign req_args[gi]  = req_args_i[gi*ARG_DW +: ARG_DW];
      // Out-of-range child indices can only exist when CHILD is not a power of two.
      if ((1 << LOG_CHILD) == CHILD) begin : g_full
        assign child_ok[gi] = 1'b1;
      end else begin : g_part
        assign child_ok[gi] = (req_child[gi] < LOG_CHILD'(CHILD));
      end
      assign eligible[gi] = req_vld_i[gi] && child_ok[gi] && !busy_q[req_child[gi]] &&
                            !((state_q == ISSUE) && (req_child[gi] == held_child_q));
    end
  endgenerate

  // First eligible parent scanning upward from rr_ptr with wrap-around.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = '0;
    for (int k = 0; k < PARENT; k++) begin
      rr_idx = {1'b0, rr_ptr_q} + (LOG_PARENT+1)'(k);
      if (rr_idx >= (LOG_PARENT+1)'(PARENT)) begin
        rr_idx = rr_idx - (LOG_PARENT+1)'(PARENT);
      end
      if (!rr_found && eligible[rr_idx[LOG_PARENT-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx[LOG_PARENT-1:0];
      end
    end
  end

`ifdef CALL_SCHED_STARVE_EN
  logic [7:0]             starve_q [PARENT];
  logic [PARENT-1:0]      starved;
  logic                   st_found;
  logic [LOG_PARENT-1:0]  st_winner;

  generate
    for (genvar gi = 0; gi < PARENT; gi++) begin : g_starve
      assign starved[gi] = eligible[gi] && (starve_q[gi] >= 8'(STARVE_LIMIT));

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          starve_q[gi] <= '0;
        end else if (!req_vld_i[gi] || grant[gi]) begin
          starve_q[gi] <= '0;
        end else if ((state_q == IDLE) && eligible[gi] && (starve_q[gi] != 8'hFF)) begin
          starve_q[gi] <= starve_q[gi] + 8'd1;
        end
      end
    end
  endgenerate

  // Promoted parents win over the round-robin pick, lowest index first.
  always_comb begin
    st_found  = 1'b0;
    st_winner = '0;
    for (int k = PARENT - 1; k >= 0; k--) begin
      if (starved[k]) begin
        st_found  = 1'b1;
        st_winner = LOG_PARENT'(k);
      end
    end
  end

  assign any_found = st_found | rr_found;
  assign winner    = st_found ? st_winner : rr_winner;
`else
  assign any_found = rr_found;
  assign winner    = rr_winner;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    held_parent_d = held_parent_q;
    held_child_d  = held_child_q;
    held_args_d   = held_args_q;
    grant         = '0;
    set_busy      = '0;
    case (state_q)
      IDLE: begin
        if (any_found) begin
          grant[winner] = 1'b1;
          held_parent_d = winner;
          held_child_d  = req_child[winner];
          held_args_d   = req_args[winner];
          rr_ptr_d      = (winner == LOG_PARENT'(PARENT - 1)) ? '0 : winner + 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (call_rdy_i[held_child_q]) begin
          set_busy[held_child_q] = 1'b1;
          state_d                = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A handshake and a done on the same child leave it busy.
  assign busy_d = (busy_q & ~child_done_i) | set_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      busy_q        <= '0;
      held_parent_q <= '0;
      held_child_q  <= '0;
      held_args_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      busy_q        <= busy_d;
      held_parent_q <= held_parent_d;
      held_child_q  <= held_child_d;
      held_args_q   <= held_args_d;
    end
  end

  // The accept pulse is combinational, so it is masked while reset is held.
  assign req_rdy_o = grant & {PARENT{rstn}};

  generate
    for (genvar gi = 0; gi < CHILD; gi++) begin : g_call
      assign call_vld_o[gi] = (state_q == ISSUE) && (held_child_q == LOG_CHILD'(gi));
    end
  endgenerate

  assign call_parent_o = held_parent_q;
  assign call_args_o   = held_args_q;
  assign child_busy_o  = busy_q;

endmodule
